// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running column/row counters, sync/active/frame decode,
// latency-matched flag pipeline and blanked, re-registered video for the DAC.
module vga_timing_gen #(
    parameter int VIDEO_WIDTH      = 3,
    parameter int ACTIVE_COLS      = 640,
    parameter int FRONT_PORCH_HORZ = 16,
    parameter int SYNC_WIDTH_HORZ  = 96,
    parameter int BACK_PORCH_HORZ  = 48,
    parameter int ACTIVE_ROWS      = 480,
    parameter int FRONT_PORCH_VERT = 10,
    parameter int SYNC_WIDTH_VERT  = 2,
    parameter int BACK_PORCH_VERT  = 33,
    parameter int SYNC_ACTIVE_HIGH = 0,
    parameter int VIDEO_DELAY      = 2,
    parameter int COUNT_WIDTH      = 10
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_Enable,
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic [COUNT_WIDTH-1:0] o_Col_Count,
    output logic [COUNT_WIDTH-1:0] o_Row_Count,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic                   o_Active,
    output logic                   o_Frame_Start,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

    localparam int TOTAL_COLS = ACTIVE_COLS + FRONT_PORCH_HORZ + SYNC_WIDTH_HORZ + BACK_PORCH_HORZ;
    localparam int TOTAL_ROWS = ACTIVE_ROWS + FRONT_PORCH_VERT + SYNC_WIDTH_VERT + BACK_PORCH_VERT;
    localparam int LAT        = VIDEO_DELAY + 1;

    localparam logic [COUNT_WIDTH-1:0] COL_LAST   = COUNT_WIDTH'(TOTAL_COLS - 1);
    localparam logic [COUNT_WIDTH-1:0] ROW_LAST   = COUNT_WIDTH'(TOTAL_ROWS - 1);
    localparam logic [COUNT_WIDTH-1:0] COL_ACT    = COUNT_WIDTH'(ACTIVE_COLS);
    localparam logic [COUNT_WIDTH-1:0] ROW_ACT    = COUNT_WIDTH'(ACTIVE_ROWS);
    localparam logic [COUNT_WIDTH-1:0] HS_FIRST   = COUNT_WIDTH'(ACTIVE_COLS + FRONT_PORCH_HORZ);
    localparam logic [COUNT_WIDTH-1:0] HS_LAST    = COUNT_WIDTH'(ACTIVE_COLS + FRONT_PORCH_HORZ + SYNC_WIDTH_HORZ - 1);
    localparam logic [COUNT_WIDTH-1:0] VS_FIRST   = COUNT_WIDTH'(ACTIVE_ROWS + FRONT_PORCH_VERT);
    localparam logic [COUNT_WIDTH-1:0] VS_LAST    = COUNT_WIDTH'(ACTIVE_ROWS + FRONT_PORCH_VERT + SYNC_WIDTH_VERT - 1);
    localparam logic                   SYNC_POL   = (SYNC_ACTIVE_HIGH != 0);
    localparam logic [COUNT_WIDTH-1:0] ONE        = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] col_q, col_d;
    logic [COUNT_WIDTH-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (!i_Enable) begin
            col_d = '0;
            row_d = '0;
        end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ONE;
        end else begin
            col_d = col_q + ONE;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Flag vector layout: {frame, active, v_sync, h_sync}; all forced off while disabled.
    logic       h_sync, v_sync, active, frame;
    logic [3:0] flags_d;

    always_comb begin
        h_sync  = (col_q >= HS_FIRST) && (col_q <= HS_LAST);
        v_sync  = (row_q >= VS_FIRST) && (row_q <= VS_LAST);
        active  = (col_q < COL_ACT) && (row_q < ROW_ACT);
        frame   = (col_q == '0) && (row_q == '0);
        flags_d = {frame, active, v_sync, h_sync} & {4{i_Enable}};
    end

    logic [3:0] pipe_q   [LAT];
    logic [3:0] stage_in [LAT];

    for (genvar gi = 0; gi < LAT; gi++) begin : g_pipe
        if (gi == 0) begin : g_first
            assign stage_in[gi] = flags_d;
        end else begin : g_rest
            assign stage_in[gi] = pipe_q[gi-1];
        end

        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                pipe_q[gi] <= '0;
            end else begin
                pipe_q[gi] <= stage_in[gi];
            end
        end
    end

    // One register stage on video lines up source data with the LAT-deep flag pipe.
    logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            red_q <= '0;
            grn_q <= '0;
            blu_q <= '0;
        end else begin
            red_q <= i_Red_Video;
            grn_q <= i_Grn_Video;
            blu_q <= i_Blu_Video;
        end
    end

    logic [3:0] tail;
    assign tail = pipe_q[LAT-1];

    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_HSync       = tail[0] ~^ SYNC_POL;
    assign o_VSync       = tail[1] ~^ SYNC_POL;
    assign o_Active      = tail[2];
    assign o_Frame_Start = tail[3];
    assign o_Red_Video   = tail[2] ? red_q : '0;
    assign o_Grn_Video   = tail[2] ? grn_q : '0;
    assign o_Blu_Video   = tail[2] ? blu_q : '0;

endmodule
